regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core.
- Provides NRD combinational read ports and NWR synchronous write ports, each with write-through bypass.
- Adds a per-register busy scoreboard for hazard detection.
- After reset, a clear sequencer zeroes the array before the file reports ready.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports.
- NWR, 1, number of write ports.
- AW, $clog2(NREGS), address width; localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- ready  out  1  high once the clear sequence has completed.
- rs_addr  in  NRD*AW  read addresses; port k uses slice k.
- rs_data  out  NRD*XLEN  read data; combinational.
- rs_busy  out  NRD  scoreboard busy bit of each read address; combinational.
- we  in  NWR  write enables.
- wa  in  NWR*AW  write addresses.
- wd  in  NWR*XLEN  write data.
- rsv_en  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  AW  register to reserve.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - FSM enters CLEAR; clear pointer = 0; all busy bits = 0; ready = 0.
- CLEAR state:
  - Each cycle with rst_n=1, writes 0 to mem[ptr], then ptr++.
  - After writing NREGS-1, moves to RUN on the next posedge. ready=1 from that cycle.
  - Total latency: NREGS cycles after rst_n rises.
  - Write-port and reservation inputs are ignored. rs_data and rs_busy read as all-zero.
  - Reset asserted mid-clear restarts the clear from ptr=0.
- RUN state: ready=1 and stays there until the next reset.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and reservations addressed to 0 are dropped.
- Read, in RUN, per port k, in priority order:
  1. addr==0 -> 0.
  2. Else, highest-index write port j with we[j] and wa[j]==addr -> wd[j] (bypass).
  3. Else mem[addr].
- Write:
  - At posedge, each enabled port j with wa[j]!=0 writes mem[wa[j]].
  - If several ports target the same address, the highest index wins. This matches the bypass priority, so the bypassed value equals the stored value.
- Scoreboard, in RUN, at posedge, for each register r!=0:
  - busy[r] is set if rsv_en and rsv_addr==r.
  - Else busy[r] is cleared if any we[j] with wa[j]==r.
  - Else busy[r] holds.
  - Reserve beats a same-cycle write to the same register: the new producer owns it.
- rs_busy[k]:
  - Reflects registered busy[rs_addr_k].
  - Forced 0 when the same cycle has a write to that address and no same-cycle reserve of it. The bypass has already supplied the data.
  - Always 0 for addr 0.
- No X propagation: every mem entry is defined after CLEAR. Out-of-range addresses cannot occur because NREGS is a power of two.

Decomposition:
- Shared package regfile_pkg holds:
  - state enum {CLEAR, RUN};
  - default XLEN/NREGS constants;
  - a function extracting slice k of a packed bus.
- One natural sub-module, regfile_scoreboard: the busy-bit array with reserve/clear priority and per-port busy lookup, parametrised by NREGS, NRD, NWR.
- Data array, bypass and clear FSM stay in regfile_mp.

Test Plan:
- Reset/clear, NREGS=32:
  - Stimulus: drive rst_n=0 for 2 cycles, then 1.
  - Response: ready=0 for exactly 32 cycles, then 1. Reading x5 returns 0. A write to x5 issued during CLEAR is discarded; x5 still reads 0 afterwards.
- Basic write/read with bypass:
  - Stimulus: we[0]=1, wa=3, wd=0xDEADBEEF; same cycle rs_addr0=3.
  - Response: rs_data0=0xDEADBEEF combinationally, and it still reads 0xDEADBEEF the next cycle with we=0.
- x0 protection:
  - Stimulus: write 0x1234 to x0 and reserve x0.
  - Response: rs_data=0 and rs_busy=0 for x0 on all following cycles.
- Dual write conflict (NWR=2):
  - Stimulus: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle.
  - Response: bypass shows 0x22 and the stored value is 0x22.
- Scoreboard:
  - Reserve x9 at cycle t -> rs_busy=1 at t+1.
  - Write x9 at t+3 -> rs_busy=0 combinationally at t+3 with data bypassed, and busy stays 0 at t+4.
  - Reserve and write x9 in the same cycle -> busy=1 the next cycle.
- Reset mid-clear:
  - Stimulus: assert rst_n=0 at cycle 10 of CLEAR, release.
  - Response: ready rises exactly 32 cycles after release, and all busy bits are 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the sequencer state type, default sizes and a packed-bus slice helper.
package regfile_pkg;

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    localparam int unsigned XlenDefault  = 32;
    localparam int unsigned NregsDefault = 32;

    // Widest packed bus and widest field the slice helper handles.
    localparam int unsigned MaxBus   = 2048;
    localparam int unsigned MaxSlice = 64;

    // Returns field k (each w bits wide) of a packed bus, zero-extended.
    function automatic logic [MaxSlice-1:0] bus_slice(input logic [MaxBus-1:0] bus,
                                                      input int unsigned k,
                                                      input int unsigned w);
        logic [MaxBus-1:0]   shifted;
        logic [MaxSlice-1:0] mask;
        shifted = bus >> (k * w);
        mask    = (MaxSlice'(1) << w) - MaxSlice'(1);
        return shifted[MaxSlice-1:0] & mask;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for hazard detection.
// A reserve beats a same-cycle write; a same-cycle write hides busy on the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NregsDefault,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic [NWR-1:0]  we,
    input  logic [NWR*AW-1:0] wa,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]  rs_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] rsv_hit;

    always_comb begin
        wr_hit  = '0;
        rsv_hit = '0;
        if (run) begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (we[j]) begin
                    wr_hit[AW'(bus_slice(MaxBus'(wa), j, AW))] = 1'b1;
                end
            end
            if (rsv_en) begin
                rsv_hit[rsv_addr] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d    = (busy_q | rsv_hit) & ~(wr_hit & ~rsv_hit);
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs_busy = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            logic [AW-1:0] a;
            a = AW'(bus_slice(MaxBus'(rs_addr), k, AW));
            if (run && a != '0) begin
                rs_busy[k] = busy_q[a] & ~(wr_hit[a] & ~rsv_hit[a]);
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through bypass and busy scoreboard.
// After reset a sequencer zeroes every entry before ready is raised.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XlenDefault,
    parameter int unsigned NREGS = NregsDefault,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr
);

    state_e          state_q;
    logic [AW-1:0]   ptr_q;
    logic [XLEN-1:0] mem [NREGS];
    logic            run;

    logic [AW-1:0]   rd_addr [NRD];
    logic [AW-1:0]   wr_addr [NWR];
    logic [XLEN-1:0] wr_data [NWR];

    assign run   = (state_q == StRun);
    assign ready = run;

    always_comb begin
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_addr[k] = AW'(bus_slice(MaxBus'(rs_addr), k, AW));
        end
        for (int unsigned j = 0; j < NWR; j++) begin
            wr_addr[j] = AW'(bus_slice(MaxBus'(wa), j, AW));
            wr_data[j] = XLEN'(bus_slice(MaxBus'(wd), j, XLEN));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else if (state_q == StClear) begin
            ptr_q <= ptr_q + AW'(1);
            if (ptr_q == AW'(NREGS - 1)) begin
                state_q <= StRun;
            end
        end
    end

    // Ascending port order: the highest-index port lands last and wins.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!run) begin
                mem[ptr_q] <= '0;
            end else begin
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (we[j] && wr_addr[j] != '0) begin
                        mem[wr_addr[j]] <= wr_data[j];
                    end
                end
            end
        end
    end

    always_comb begin
        rs_data = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            if (run && rd_addr[k] != '0) begin
                rs_data[k*XLEN +: XLEN] = mem[rd_addr[k]];
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (we[j] && wr_addr[j] == rd_addr[k]) begin
                        rs_data[k*XLEN +: XLEN] = wr_data[j];
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .we       (we),
        .wa       (wa),
        .rs_addr  (rs_addr),
        .rs_busy  (rs_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (XLEN=32, NREGS=32, NRD=2, NWR=2).
// Directed scenarios plus random traffic, compared against an array-based reference model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural contents, busy flags, cycles left in the clear.
    logic [31:0] m_mem  [32];
    bit          m_busy [32];
    int          clear_left = -1;
    bit          known = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN  (32),
        .NREGS (32),
        .NRD   (2),
        .NWR   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit write_hits(input logic [4:0] a);
        bit hit = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (we[j] && wa[j*5 +: 5] == a) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] v;
        if (clear_left != 0 || a == 5'd0) return 32'd0;
        v = m_mem[a];
        for (int j = 0; j < 2; j++) begin
            if (we[j] && wa[j*5 +: 5] == a) v = wd[j*32 +: 32];
        end
        return v;
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
        bit rsv;
        if (clear_left != 0 || a == 5'd0) return 1'b0;
        rsv = rsv_en && rsv_addr == a;
        return m_busy[a] && !(write_hits(a) && !rsv);
    endfunction

    task automatic check_outputs();
        logic [4:0] a;
        check("ready", 64'(ready), 64'(clear_left == 0));
        for (int k = 0; k < 2; k++) begin
            a = rs_addr[k*5 +: 5];
            check("rd_data", 64'(rs_data[k*32 +: 32]), 64'(exp_rd(a)));
            check("rd_busy", 64'(rs_busy[k]), 64'(exp_busy(a)));
        end
    endtask

    task automatic update_model();
        bit nb [32];
        if (!rst_n) begin
            clear_left = 32;
            known      = 1'b1;
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  = 32'd0;
                m_busy[r] = 1'b0;
            end
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            for (int r = 1; r < 32; r++) begin
                nb[r] = m_busy[r];
                if (rsv_en && rsv_addr == 5'(r)) nb[r] = 1'b1;
                else if (write_hits(5'(r)))      nb[r] = 1'b0;
            end
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wa[j*5 +: 5] != 5'd0) m_mem[wa[j*5 +: 5]] = wd[j*32 +: 32];
            end
            for (int r = 1; r < 32; r++) m_busy[r] = nb[r];
        end
    endtask

    // Inputs are already applied; compare, take the edge, advance the model.
    task automatic tick();
        #2;
        if (known) check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle();
        we       = '0;
        wa       = '0;
        wd       = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        rs_addr  = '0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'd32);
    endtask

    initial begin
        logic [4:0] a0, a1;
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst_n = 1'b1;

        // Write to x5 held during the whole clear must be discarded.
        we      = 2'b01;
        wa      = {5'd0, 5'd5};
        wd      = {32'd0, 32'h0000CAFE};
        rs_addr = {5'd0, 5'd5};
        wait_ready("clear_len");
        idle();
        rs_addr = {5'd0, 5'd5};
        #2 check("x5_after_clear", 64'(rs_data[31:0]), 64'd0);
        tick();

        // Bypass and subsequent stored read.
        we      = 2'b01;
        wa      = {5'd0, 5'd3};
        wd      = {32'd0, 32'hDEADBEEF};
        rs_addr = {5'd0, 5'd3};
        #2 check("bypass", 64'(rs_data[31:0]), 64'hDEADBEEF);
        tick();
        idle();
        rs_addr = {5'd3, 5'd3};
        #2 check("stored", 64'(rs_data[63:32]), 64'hDEADBEEF);
        tick();

        // x0 protection.
        we       = 2'b01;
        wa       = '0;
        wd       = {32'd0, 32'h00001234};
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        tick();
        idle();
        repeat (3) begin
            #2 check("x0_data", rs_data, 64'd0);
            check("x0_busy", 64'(rs_busy), 64'd0);
            tick();
        end

        // Two ports writing the same register: port 1 wins.
        we      = 2'b11;
        wa      = {5'd7, 5'd7};
        wd      = {32'h00000022, 32'h00000011};
        rs_addr = {5'd0, 5'd7};
        #2 check("dual_bypass", 64'(rs_data[31:0]), 64'h22);
        tick();
        idle();
        rs_addr = {5'd0, 5'd7};
        #2 check("dual_stored", 64'(rs_data[31:0]), 64'h22);
        tick();

        // Scoreboard: reserve, hold, clearing write, reserve-beats-write.
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        tick();
        idle();
        rs_addr = {5'd9, 5'd9};
        #2 check("busy_t1", 64'(rs_busy[0]), 64'd1);
        tick();
        tick();
        we = 2'b01;
        wa = {5'd0, 5'd9};
        wd = {32'd0, 32'h0000ABCD};
        #2 check("busy_on_write", 64'(rs_busy[0]), 64'd0);
        check("data_on_write", 64'(rs_data[31:0]), 64'hABCD);
        tick();
        we = '0;
        #2 check("busy_t4", 64'(rs_busy), 64'd0);
        tick();
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        we       = 2'b01;
        wa       = {5'd0, 5'd9};
        wd       = {32'd0, 32'h00005555};
        tick();
        idle();
        rs_addr = {5'd0, 5'd9};
        #2 check("rsv_beats_wr", 64'(rs_busy[0]), 64'd1);
        check("rsv_wr_data", 64'(rs_data[31:0]), 64'h5555);
        tick();

        // Random traffic on a narrowed address range to force collisions.
        for (int i = 0; i < 3000; i++) begin
            we          = 2'($urandom_range(0, 3));
            wa[4:0]     = 5'($urandom_range(0, 11));
            wa[9:5]     = 5'($urandom_range(0, 11));
            wd[31:0]    = $urandom;
            wd[63:32]   = $urandom;
            rsv_en      = ($urandom_range(0, 2) == 0);
            rsv_addr    = 5'($urandom_range(0, 11));
            a0          = 5'($urandom_range(0, 31));
            a1          = 5'($urandom_range(0, 3) == 0) ? wa[4:0] : 5'($urandom_range(0, 11));
            rs_addr     = {a1, a0};
            tick();
        end
        idle();

        // Reset in the middle of the clear restarts it and leaves nothing busy.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_ready("midclear_len");
        for (int r = 0; r < 32; r += 2) begin
            rs_addr = {5'(r + 1), 5'(r)};
            #2 check("sweep_busy", 64'(rs_busy), 64'd0);
            check("sweep_data", rs_data, 64'd0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
